// File: rtl/clock_mode_ctrl.sv
// Clock-setting controller: debounced mode/select/increment buttons driving a 4-state FSM.
// Optional build macro AUTO_REPEAT_EN adds hold-to-repeat on the increment button.
module clock_mode_ctrl #(
  parameter int unsigned DEB_CNT    = 500000,
  parameter int unsigned BLINK_HALF = 12500000,
  parameter int unsigned REP_DLY    = 25000000,
  parameter int unsigned REP_PER    = 5000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sw0,
  input  logic       i_sw1,
  input  logic       i_sw2,
  input  logic       i_tick_1hz,
  input  logic       i_sec_carry,
  input  logic       i_min_carry,
  output logic [1:0] o_mode,
  output logic       o_sec_inc,
  output logic       o_min_inc,
  output logic       o_hour_inc,
  output logic [5:0] o_blink_mask
);

  localparam int unsigned DebW   = $clog2(DEB_CNT + 1);
  localparam int unsigned BlinkW = $clog2(2 * BLINK_HALF);

  typedef enum logic [1:0] {
    StClock   = 2'd0,
    StSetSec  = 2'd1,
    StSetMin  = 2'd2,
    StSetHour = 2'd3
  } state_e;

  logic [2:0]      sw_raw;
  logic [2:0]      sync1_q, sync2_q;
  logic [2:0]      deb_q, deb_d;
  logic [2:0]      press_q, press_d;
  logic [DebW-1:0] cnt_q [3];
  logic [DebW-1:0] cnt_d [3];

  state_e            state_q, state_d;
  logic              sec_inc_d, min_inc_d, hour_inc_d;
  logic [BlinkW-1:0] blink_q, blink_d;
  logic [5:0]        mask_d;
  logic              blink_on;
  logic              inc_req;
  logic              rep_fire;

  assign sw_raw = {i_sw2, i_sw1, i_sw0};

  // Debounced level follows the synchronized input only after DEB_CNT steady cycles.
  always_comb begin
    deb_d   = deb_q;
    press_d = '0;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DebW'(DEB_CNT - 1)) begin
          deb_d[i]   = sync2_q[i];
          press_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      deb_q   <= '1;
      press_q <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      press_q <= press_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RepMax = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
  localparam int unsigned RepW   = $clog2(RepMax + 1);

  logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
  logic            rep_act_q, rep_act_d;
  logic            rep_rpt_q, rep_rpt_d;

  // First repeat after REP_DLY cycles, then every REP_PER, while sw2 stays held in the same state.
  assign rep_fire = rep_act_q &&
                    (rep_rpt_q ? (rep_cnt_q == RepW'(REP_PER)) : (rep_cnt_q == RepW'(REP_DLY)));

  always_comb begin
    rep_act_d = rep_act_q && !deb_q[2] && (state_d == state_q) && (state_q != StClock);
    rep_cnt_d = rep_cnt_q + 1'b1;
    rep_rpt_d = rep_rpt_q;
    if (rep_fire) begin
      rep_cnt_d = RepW'(1);
      rep_rpt_d = 1'b1;
    end
    if (press_q[2] && !press_q[1] && !press_q[0] && (state_q != StClock)) begin
      rep_act_d = 1'b1;
      rep_cnt_d = RepW'(1);
      rep_rpt_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q <= '0;
      rep_act_q <= 1'b0;
      rep_rpt_q <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      rep_act_q <= rep_act_d;
      rep_rpt_q <= rep_rpt_d;
    end
  end
`else
  logic unused_rep;
  assign unused_rep = (REP_DLY == REP_PER);
  assign rep_fire   = 1'b0;
`endif

  assign inc_req = press_q[2] || rep_fire;

  always_comb begin
    state_d    = state_q;
    sec_inc_d  = 1'b0;
    min_inc_d  = 1'b0;
    hour_inc_d = 1'b0;
    unique case (state_q)
      StClock: begin
        if (press_q[0]) state_d = StSetSec;
        // Prioritised so at most one increment leaves per cycle.
        if (i_tick_1hz)       sec_inc_d  = 1'b1;
        else if (i_sec_carry) min_inc_d  = 1'b1;
        else if (i_min_carry) hour_inc_d = 1'b1;
      end
      default: begin
        if (press_q[0]) begin
          state_d = StClock;
        end else if (press_q[1]) begin
          state_d = (state_q == StSetHour) ? StSetSec : state_e'(state_q + 2'd1);
        end else if (inc_req) begin
          sec_inc_d  = (state_q == StSetSec);
          min_inc_d  = (state_q == StSetMin);
          hour_inc_d = (state_q == StSetHour);
        end
      end
    endcase
  end

  always_comb begin
    if (state_d != state_q)                         blink_d = '0;
    else if (blink_q == BlinkW'(2 * BLINK_HALF - 1)) blink_d = '0;
    else                                            blink_d = blink_q + 1'b1;
    blink_on = (blink_d >= BlinkW'(BLINK_HALF));
    mask_d   = '0;
    unique case (state_d)
      StSetSec:  mask_d[1:0] = {2{blink_on}};
      StSetMin:  mask_d[3:2] = {2{blink_on}};
      StSetHour: mask_d[5:4] = {2{blink_on}};
      default:   mask_d      = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StClock;
      blink_q      <= '0;
      o_sec_inc    <= 1'b0;
      o_min_inc    <= 1'b0;
      o_hour_inc   <= 1'b0;
      o_blink_mask <= '0;
    end else begin
      state_q      <= state_d;
      blink_q      <= blink_d;
      o_sec_inc    <= sec_inc_d;
      o_min_inc    <= min_inc_d;
      o_hour_inc   <= hour_inc_d;
      o_blink_mask <= mask_d;
    end
  end

  assign o_mode = state_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl with short debounce/blink/repeat parameters.
module tb_clock_mode_ctrl;
  localparam int unsigned DEB = 4;
  localparam int unsigned BH  = 8;
  localparam int unsigned RD  = 20;
  localparam int unsigned RP  = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw0 = 1'b1, sw1 = 1'b1, sw2 = 1'b1;
  logic       tick = 1'b0, sc = 1'b0, mc = 1'b0;
  logic [1:0] mode;
  logic       sec_inc, min_inc, hour_inc;
  logic [5:0] mask;

  always #5 clk = ~clk;

  clock_mode_ctrl #(
    .DEB_CNT   (DEB),
    .BLINK_HALF(BH),
    .REP_DLY   (RD),
    .REP_PER   (RP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_sw0       (sw0),
    .i_sw1       (sw1),
    .i_sw2       (sw2),
    .i_tick_1hz  (tick),
    .i_sec_carry (sc),
    .i_min_carry (mc),
    .o_mode      (mode),
    .o_sec_inc   (sec_inc),
    .o_min_inc   (min_inc),
    .o_hour_inc  (hour_inc),
    .o_blink_mask(mask)
  );

  int          n_checks = 0;
  int          n_err    = 0;
  int unsigned ncyc = 0, n_sec = 0, n_min = 0, n_hour = 0, n_multi = 0;
  int unsigned n_mode_chg = 0, enter_cyc = 0;
  int unsigned sec_cyc[$];
  logic [1:0]  mode_prev = 2'd0;

  // Output monitor: pulse counts, sec pulse times, mode-entry time.
  always @(negedge clk) begin
    ncyc++;
    if (sec_inc) begin
      n_sec++;
      sec_cyc.push_back(ncyc);
    end
    if (min_inc) n_min++;
    if (hour_inc) n_hour++;
    if (int'(sec_inc) + int'(min_inc) + int'(hour_inc) > 1) n_multi++;
    if (mode != mode_prev) begin
      n_mode_chg++;
      enter_cyc = ncyc;
    end
    mode_prev = mode;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic set_sw(input int idx, input logic v);
    case (idx)
      0:       sw0 = v;
      1:       sw1 = v;
      default: sw2 = v;
    endcase
  endtask

  task automatic press_sw(input int idx);
    set_sw(idx, 1'b0);
    cycles(10);
    set_sw(idx, 1'b1);
    cycles(10);
  endtask

  int unsigned b_sec, b_min, b_hour, b_chg, qb;
  int          exp_mask;

  initial begin
    rst_n = 1'b0;
    cycles(3);
    check_eq("rst_mode", int'(mode), 0);
    check_eq("rst_mask", int'(mask), 0);
    check_eq("rst_incs", int'(sec_inc) + int'(min_inc) + int'(hour_inc), 0);
    rst_n = 1'b1;
    cycles(2);

    // CLOCK mode pass-through, one cycle latency
    b_sec = n_sec;
    cycles(8);
    tick = 1'b1; cycles(1); tick = 1'b0;
    check_eq("tick1_sec_inc", int'(sec_inc), 1);
    cycles(1);
    check_eq("tick1_sec_inc_clear", int'(sec_inc), 0);
    cycles(8);
    tick = 1'b1; cycles(1); tick = 1'b0;
    check_eq("tick2_sec_inc", int'(sec_inc), 1);
    cycles(5);
    check_eq("tick_pulse_count", int'(n_sec - b_sec), 2);
    sc = 1'b1; cycles(1); sc = 1'b0;
    check_eq("sec_carry_min_inc", int'(min_inc), 1);
    mc = 1'b1; cycles(1); mc = 1'b0;
    check_eq("min_carry_hour_inc", int'(hour_inc), 1);
    check_eq("min_carry_no_min", int'(min_inc), 0);
    check_eq("clock_mode", int'(mode), 0);
    check_eq("clock_mask", int'(mask), 0);

    // sw2 and sw1 ignored in CLOCK
    b_sec = n_sec; b_min = n_min; b_hour = n_hour;
    press_sw(2);
    press_sw(1);
    check_eq("clock_sw2_ignored", int'((n_sec - b_sec) + (n_min - b_min) + (n_hour - b_hour)), 0);
    check_eq("clock_sw1_ignored", int'(mode), 0);

    // Glitches shorter than the debounce window
    b_chg = n_mode_chg;
    sw0 = 1'b0; cycles(2); sw0 = 1'b1; cycles(2);
    sw0 = 1'b0; cycles(2); sw0 = 1'b1; cycles(8);
    check_eq("glitch_mode", int'(mode), 0);
    check_eq("glitch_no_change", int'(n_mode_chg - b_chg), 0);
    sw0 = 1'b0; cycles(10); sw0 = 1'b1; cycles(10);
    check_eq("sw0_to_set_sec", int'(mode), 1);
    check_eq("sw0_single_change", int'(n_mode_chg - b_chg), 1);

    // Time frozen in SET_*
    b_sec = n_sec; b_min = n_min;
    tick = 1'b1; sc = 1'b1; cycles(1); tick = 1'b0; sc = 1'b0;
    cycles(3);
    check_eq("set_tick_ignored", int'((n_sec - b_sec) + (n_min - b_min)), 0);

    // SET_MIN: blink phase, one min_inc per press, carries ignored
    b_sec = n_sec; b_min = n_min; b_hour = n_hour;
    sw1 = 1'b0;
    for (int k = 0; k < 48; k++) begin
      if (k == 10) sw1 = 1'b1;
      if (k == 20) sw2 = 1'b0;
      if (k == 30) sw2 = 1'b1;
      sc   = (k == 25 || k == 27);
      tick = (k == 26);
      cycles(1);
      if (k >= 12) begin
        exp_mask = (((ncyc - enter_cyc) % (2 * BH)) >= BH) ? 6'b001100 : 0;
        check_eq("set_min_blink", int'(mask), exp_mask);
      end
    end
    sc = 1'b0; tick = 1'b0;
    cycles(10);
    check_eq("set_min_mode", int'(mode), 2);
    check_eq("set_min_one_inc", int'(n_min - b_min), 1);
    check_eq("set_min_no_other", int'((n_sec - b_sec) + (n_hour - b_hour)), 0);

    press_sw(1);
    check_eq("to_set_hour", int'(mode), 3);
    press_sw(1);
    check_eq("hour_wraps_to_sec", int'(mode), 1);

    // sw0 beats sw2
    b_sec = n_sec; b_min = n_min; b_hour = n_hour;
    sw0 = 1'b0; sw2 = 1'b0; cycles(10);
    sw0 = 1'b1; sw2 = 1'b1; cycles(10);
    check_eq("sw0_sw2_mode", int'(mode), 0);
    check_eq("sw0_sw2_no_inc", int'((n_sec - b_sec) + (n_min - b_min) + (n_hour - b_hour)), 0);

    // sw1 beats sw2
    press_sw(0);
    b_sec = n_sec; b_min = n_min; b_hour = n_hour;
    sw1 = 1'b0; sw2 = 1'b0; cycles(10);
    sw1 = 1'b1; sw2 = 1'b1; cycles(10);
    check_eq("sw1_sw2_mode", int'(mode), 2);
    check_eq("sw1_sw2_no_inc", int'((n_sec - b_sec) + (n_min - b_min) + (n_hour - b_hour)), 0);
    press_sw(0);
    check_eq("back_to_clock", int'(mode), 0);
    press_sw(0);
    check_eq("enter_set_sec", int'(mode), 1);

    // Held sw2 in SET_SEC
    b_sec = n_sec;
    qb = sec_cyc.size();
    sw2 = 1'b0; cycles(38); sw2 = 1'b1; cycles(20);
`ifdef AUTO_REPEAT_EN
    check_eq("repeat_count", int'(n_sec - b_sec), 5);
    if (sec_cyc.size() >= qb + 4) begin
      check_eq("repeat_first_gap", int'(sec_cyc[qb + 1] - sec_cyc[qb]), 20);
      check_eq("repeat_gap2", int'(sec_cyc[qb + 2] - sec_cyc[qb + 1]), 5);
      check_eq("repeat_gap3", int'(sec_cyc[qb + 3] - sec_cyc[qb + 2]), 5);
    end
`else
    check_eq("hold_single_inc", int'(n_sec - b_sec), 1);
`endif

    // Reset mid-setup with sw2 held
    press_sw(1);
    check_eq("pre_rst_set_min", int'(mode), 2);
    b_min = n_min;
    sw2 = 1'b0; cycles(12);
    check_eq("pre_rst_min_inc", int'(n_min - b_min), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_mode", int'(mode), 0);
    check_eq("async_rst_mask", int'(mask), 0);
    check_eq("async_rst_incs", int'(sec_inc) + int'(min_inc) + int'(hour_inc), 0);
    cycles(2);
    rst_n = 1'b1;
    b_sec = n_sec; b_min = n_min; b_hour = n_hour;
    cycles(40);
    sw2 = 1'b1;
    cycles(12);
    check_eq("post_rst_no_inc", int'((n_sec - b_sec) + (n_min - b_min) + (n_hour - b_hour)), 0);
    check_eq("post_rst_mode", int'(mode), 0);

    check_eq("inc_onehot", int'(n_multi), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
